// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes from the decoder,
// the WDSel encoding that selects memory data for writeback, and the FSM
// state encoding used by the top level.
package lsu_pkg;

  // ls width codes (one-hot on the narrow widths, all-zero for word)
  localparam logic [3:0] LS_W  = 4'b0000;
  localparam logic [3:0] LS_H  = 4'b1000;
  localparam logic [3:0] LS_B  = 4'b0100;
  localparam logic [3:0] LS_HU = 4'b0010;
  localparam logic [3:0] LS_BU = 4'b0001;

  // decoder WDSel codes; WDSEL_MEM marks a load
  localparam logic [1:0] WDSEL_ALU = 2'b00;
  localparam logic [1:0] WDSEL_MEM = 2'b01;
  localparam logic [1:0] WDSEL_PC4 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic ls_valid(input logic [3:0] code);
    return (code == LS_W) || (code == LS_H) || (code == LS_B) ||
           (code == LS_HU) || (code == LS_BU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   mem_read, mem_write, ls, addr_lo, wdata : live request from the decoder
//   be, st_data, illegal                    : enables, replicated store data and
//                                             legality check for that request
//   ld_ls, ld_addr_lo, ld_word              : latched width/offset plus bus word
//   ld_data                                 : extracted and extended load value
module lsu_align
  import lsu_pkg::*;
(
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  ls,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [3:0]  ld_ls,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic        illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be      = 4'b1111;
    st_data = wdata;
    case (ls)
      LS_B, LS_BU: begin
        be      = 4'b0001 << addr_lo;
        st_data = {4{wdata[7:0]}};
      end
      LS_H, LS_HU: begin
        be      = 4'b0011 << {addr_lo[1], 1'b0};
        st_data = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_addr_lo)
      2'd0:    byte_sel = ld_word[7:0];
      2'd1:    byte_sel = ld_word[15:8];
      2'd2:    byte_sel = ld_word[23:16];
      default: byte_sel = ld_word[31:24];
    endcase
    half_sel = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_ls)
      LS_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      LS_BU:   ld_data = {24'd0, byte_sel};
      LS_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      LS_HU:   ld_data = {16'd0, half_sel};
      default: ld_data = ld_word;
    endcase
  end

  // unsigned widths exist only for loads
  assign illegal = (mem_read == mem_write) ||
                   !ls_valid(ls) ||
                   (mem_write && ((ls == LS_HU) || (ls == LS_BU))) ||
                   (((ls == LS_H) || (ls == LS_HU)) && addr_lo[0]) ||
                   ((ls == LS_W) && (addr_lo != 2'b00));

endmodule

// File: rtl/lsu.sv
// Load/store unit: runs one req/ack data-bus transaction per load/store,
// stalls the core meanwhile and reports completion with done/fault.
// Ports:
//   clk, rst                      : clock, async active-high reset
//   start, mem_write, mem_read,
//   ls, addr, wdata               : request from decoder/ALU/rs2
//   stall, done, fault, rdata     : core handshake and load result
//   bus_req, bus_we, bus_addr,
//   bus_be, bus_wdata             : registered bus request
//   bus_ack, bus_rdata            : bus response
// TIMEOUT = max wait cycles before a fault; 0 waits forever.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [3:0]  ls,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  state_t           state, state_nxt;
  logic [3:0]       ls_q;
  logic [1:0]       addr_lo_q;
  logic [CNT_W-1:0] cnt;
  logic             illegal;
  logic [3:0]       be_c;
  logic [31:0]      st_c, ld_c;
  logic             go_bus, ack_ok, flt_nxt, timeout_hit;

  lsu_align u_align (
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ls         (ls),
    .addr_lo    (addr[1:0]),
    .wdata      (wdata),
    .ld_ls      (ls_q),
    .ld_addr_lo (addr_lo_q),
    .ld_word    (bus_rdata),
    .be         (be_c),
    .st_data    (st_c),
    .ld_data    (ld_c),
    .illegal    (illegal)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_CNT);
  assign stall       = ((state == ST_IDLE) && start) || (state == ST_BUS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go_bus    = 1'b0;
    ack_ok    = 1'b0;
    flt_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (illegal) begin
            state_nxt = ST_RESP;
            flt_nxt   = 1'b1;
          end else begin
            state_nxt = ST_BUS;
            go_bus    = 1'b1;
          end
        end
      end
      ST_BUS: begin
        // an ack on the final wait cycle still counts as success
        if (bus_ack) begin
          state_nxt = ST_RESP;
          ack_ok    = 1'b1;
        end else if (timeout_hit) begin
          state_nxt = ST_RESP;
          flt_nxt   = 1'b1;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done      <= 1'b0;
      fault     <= 1'b0;
      rdata     <= 32'd0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
      ls_q      <= LS_W;
      addr_lo_q <= 2'd0;
      cnt       <= '0;
    end else begin
      done  <= (state_nxt == ST_RESP);
      fault <= flt_nxt;
      if (go_bus) begin
        bus_req   <= 1'b1;
        bus_we    <= mem_write;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_be    <= be_c;
        bus_wdata <= st_c;
        ls_q      <= ls;
        addr_lo_q <= addr[1:0];
        cnt       <= '0;
      end else if (state == ST_BUS) begin
        if (state_nxt != ST_BUS) bus_req <= 1'b0;
        else                     cnt     <= cnt + CNT_W'(1);
      end
      if (ack_ok && !bus_we) rdata <= ld_c;
    end
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, mem_write, mem_read;
  logic [3:0]  ls;
  logic [31:0] addr, wdata;
  logic        stall, done, fault;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_rdata = 32'd0;

  lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_write(mem_write), .mem_read(mem_read),
    .ls(ls), .addr(addr), .wdata(wdata), .stall(stall), .done(done), .fault(fault),
    .rdata(rdata), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access from the core's point of view. waits = cycles before ack;
  // anything above TO means the bus never answers in time.
  task automatic run(input logic rd, input logic wr, input logic [3:0] lsv,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int waits, input logic [31:0] word);
    int      width, off, done_cyc;
    bit      valid, uns, sgn, legal, to;
    longint  v;
    logic [31:0] e_be, e_wd, e_ld;
    valid = 1; uns = 0; sgn = 0; width = 4;
    case (lsv)
      4'b0000: width = 4;
      4'b1000: begin width = 2; sgn = 1; end
      4'b0100: begin width = 1; sgn = 1; end
      4'b0010: begin width = 2; uns = 1; end
      4'b0001: begin width = 1; uns = 1; end
      default: valid = 0;
    endcase
    off   = int'(a[1:0]);
    legal = valid && (rd != wr) && !(wr && uns) && ((off % width) == 0);
    to    = legal && (waits > TO);
    done_cyc = !legal ? 1 : (to ? TO + 2 : 2 + waits);
    e_be = 32'(((1 << width) - 1) << off);
    if (width == 1)      e_wd = (wd & 32'hFF) * 32'h01010101;
    else if (width == 2) e_wd = (wd & 32'hFFFF) * 32'h00010001;
    else                 e_wd = wd;
    v = (longint'(word) >> (8 * off)) & ((64'd1 << (8 * width)) - 1);
    if (sgn && width < 4 && v >= (64'd1 << (8 * width - 1))) v = v - (64'd1 << (8 * width));
    e_ld = v[31:0];

    mem_read = rd; mem_write = wr; ls = lsv; addr = a; wdata = wd;
    start = 1'b1; bus_ack = 1'b0; bus_rdata = $urandom;
    #1;
    chk("stall_c0", stall, 1);
    chk("req_c0", bus_req, 0);
    for (int c = 1; c <= done_cyc; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      chk("done", done, (c == done_cyc));
      chk("bus_req", bus_req, (legal && c < done_cyc));
      chk("stall", stall, (c < done_cyc));
      if (c == 1 && legal) begin
        chk("bus_addr", bus_addr, a & ~32'd3);
        chk("bus_be", bus_be, e_be);
        chk("bus_we", bus_we, wr);
        if (wr) chk("bus_wdata", bus_wdata, e_wd);
      end
      if (c == done_cyc) begin
        chk("fault", fault, (!legal || to));
        if (rd && legal && !to) model_rdata = e_ld;
        chk("rdata", rdata, model_rdata);
      end
      bus_ack   = legal && (c == 1 + waits);
      bus_rdata = bus_ack ? word : $urandom;
    end
    bus_ack = 1'b0;
    @(posedge clk); #1;
    chk("done_after", done, 0);
    chk("req_after", bus_req, 0);
  endtask

  initial begin
    logic [3:0] codes [8];
    logic rd, wr;
    int w;
    codes = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1111, 4'b0011, 4'b1100};

    rst = 1'b1; start = 0; mem_write = 0; mem_read = 0; ls = 0; addr = 0; wdata = 0;
    bus_ack = 0; bus_rdata = 0;
    #1;
    chk("rst_req", bus_req, 0);
    chk("rst_we", bus_we, 0);
    chk("rst_be", bus_be, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // word load, ack in the request cycle
    run(1, 0, 4'b0000, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    // byte/half loads from 0x80FF7F01
    run(1, 0, 4'b0100, 32'h3, 32'h0, 1, 32'h80FF7F01);
    run(1, 0, 4'b0001, 32'h3, 32'h0, 2, 32'h80FF7F01);
    run(1, 0, 4'b1000, 32'h2, 32'h0, 0, 32'h80FF7F01);
    // stores
    run(0, 1, 4'b0100, 32'h21, 32'h12345678, 1, 32'h0);
    run(0, 1, 4'b1000, 32'h22, 32'h12345678, 0, 32'h0);
    // illegal accesses
    run(1, 0, 4'b0000, 32'h102, 32'h0, 0, 32'h11111111);
    run(0, 1, 4'b0010, 32'h22, 32'h12345678, 0, 32'h0);
    run(1, 1, 4'b0000, 32'h40, 32'h0, 0, 32'h0);
    // timeout: rdata keeps the previous load
    run(1, 0, 4'b0000, 32'h200, 32'h0, 100, 32'hCAFEF00D);

    // reset during a waiting read with ack arriving just before reset
    mem_read = 1; mem_write = 0; ls = 4'b0000; addr = 32'h40; start = 1;
    @(posedge clk); #1; start = 0;
    chk("mid_req", bus_req, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'h55AA55AA;
    #2; rst = 1'b1; #1;
    model_rdata = 32'd0;
    chk("mid_rst_req", bus_req, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rdata", rdata, model_rdata);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("mid_rst_done2", done, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_done", done, 0);
    run(1, 0, 4'b0000, 32'h44, 32'h0, 1, 32'h0BADF00D);

    // randomized accesses
    for (int i = 0; i < 60; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 9) == 0) ? rd : !rd;
      w  = ($urandom_range(0, 7) == 0) ? 8 : $urandom_range(0, 3);
      run(rd, wr, codes[$urandom_range(0, 7)], $urandom, $urandom, w, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RV32I core, directly downstream of the control decoder. Consumes the decoder's `MemWrite`, load-select and 4-bit `ls` width code plus the ALU-computed address. Runs a req/ack transaction on the data-memory bus with byte lanes and enables, and returns a sign- or zero-extended load result. Stalls the core until the access completes, and flags misaligned, illegal or timed-out accesses without corrupting memory.

## Interface
- `TIMEOUT`, default 255: maximum bus-wait cycles before a fault is raised; 0 disables the timeout.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: the current instruction is a load or store. Level signal, sampled only in IDLE.
- `mem_write` in 1: store (decoder `MemWrite`).
- `mem_read` in 1: load (decoder `WDSel==01`).
- `ls` in 4: width code. 0000 = w, 1000 = h, 0100 = b, 0010 = hu, 0001 = bu.
- `addr` in 32: byte address from the ALU.
- `wdata` in 32: store data (rs2).
- `stall` out 1: hold the PC and the register file.
- `done` out 1: one-cycle pulse when the access completes.
- `fault` out 1: valid with `done`; the access was aborted.
- `rdata` out 32: extended load result.
- `bus_req` out 1: bus request.
- `bus_we` out 1: bus write.
- `bus_addr` out 32: word-aligned address (`addr & ~3`).
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_ack` in 1: bus completion; may assert in the same cycle as `bus_req`.
- `bus_rdata` in 32: read word, valid with `bus_ack`.

## Operation
- FSM has three states: IDLE, BUS, RESP.
- **IDLE, `start`=0:** no action.
- **IDLE, `start`=1, access legal:** latch `addr`, `ls`, `mem_write`, `wdata`; go to BUS.
- **IDLE, `start`=1, access illegal:** go to RESP with `fault`=1 and issue no bus cycle. An access is illegal if any of the following holds:
  - `mem_read`==`mem_write`;
  - `ls` is not a listed code;
  - a store uses hu or bu;
  - h/hu with `addr[0]`=1;
  - w with `addr[1:0]`≠0.
- **BUS:**
  - `bus_req`=1, with `bus_we`/`bus_addr`/`bus_be`/`bus_wdata` driven from the latched values.
  - On `bus_ack`: load → capture the extended `bus_rdata` into `rdata`; go to RESP with `fault`=0.
  - Wait counter increments each cycle without `bus_ack`. When it reaches `TIMEOUT` (nonzero), go to RESP with `fault`=1 and leave `rdata` unchanged.
- **RESP:** `done`=1 for one cycle; return to IDLE. `start` is ignored in RESP.
- **Byte enables:**
  - b: `0001<<addr[1:0]`.
  - h: `0011<<{addr[1],1'b0}`.
  - w: `1111`.
- **Store data:** b → `{4{wdata[7:0]}}`, h → `{2{wdata[15:0]}}`, w → `wdata`.
- **Load extract:**
  - Select the lane from `addr[1:0]`.
  - b/h sign-extend from bit 7/15; bu/hu zero-extend.
  - `rdata` holds its value until the next successful load.
- `stall` = (IDLE & `start`) | BUS. It is combinational, so the core holds the instruction from the first cycle; it is low in RESP so the PC advances at the end of RESP.
- Stores never write `rdata`.

## Timing
- **Reset values:** state IDLE, `rdata`=0, `done`=0, `fault`=0, `bus_req`=0, `bus_we`=0, `bus_be`=0, `bus_addr`=0, `bus_wdata`=0, counter 0.
- **Legal access, ack after w wait cycles:** `start` at cycle 0, `bus_req` cycles 1..1+w, ack at cycle 1+w, `done` at cycle 2+w. The minimum is done at cycle 2, with `stall` high in cycles 0–1.
- **Illegal access:** `done`+`fault` at cycle 1, `stall` high in cycle 0 only.
- **Timeout:** `done`+`fault` at cycle `TIMEOUT`+2; `bus_req` drops the cycle after the timeout is detected.
- All bus outputs are registered; `bus_req` never toggles while awaiting ack.
- Reset asserted mid-BUS: `bus_req` drops asynchronously, no `done` is produced, and a partially acked read is discarded.

## Structure
- **`lsu_pkg`:** `ls` code constants (LS_W, LS_H, LS_B, LS_HU, LS_BU), the FSM state encoding, and the WDSel codes.
- **Sub-module `lsu_align`:** purely combinational; computes `bus_be`, lane-replicated store data, the load extract/extend, and the misalign/illegal check.
- The top level holds the FSM, latches and timeout counter (width `$clog2(TIMEOUT+1)`).

## Test plan
- **Word load, zero-wait:** `start`, `mem_read`, `ls`=0000, `addr`=0x100, ack with 0xDEADBEEF in the req cycle → `bus_be`=1111, `bus_addr`=0x100, `done` at cycle 2, `rdata`=0xDEADBEEF.
- **Signed/unsigned byte loads:** word 0x80FF7F01 at lanes 0..3 →
  - lb at `addr`=0x3 gives 0xFFFFFF80;
  - lbu at 0x3 gives 0x00000080;
  - lh at 0x2 gives 0xFFFF80FF.
- **Stores:**
  - sb of 0x12345678 at `addr`=0x21 → `bus_be`=0010, `bus_wdata`=0x78787878, `bus_addr`=0x20.
  - sh at 0x22 → `bus_be`=1100, `bus_wdata`=0x56785678.
- **Faults:**
  - lw at 0x102 → `done`+`fault` at cycle 1, `bus_req` never high.
  - sh with `ls`=0010 → fault.
- **Timeout:** `TIMEOUT`=4, no ack → `fault` at cycle 6, `rdata` unchanged, then back to IDLE.
- **Reset mid-transaction:** assert `rst` during BUS with 3 wait cycles → `bus_req`=0 immediately, no `done`. After release, a new lw completes normally.
